// File: rtl/rv32_pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: derives per-stage stall and
// flush controls and sequences fence drains and post-trap redirect bubbles.
module rv32_pipeline_ctrl #(
  parameter int FENCE_DRAIN_CYCLES = 3,
  parameter int TRAP_HOLD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic       dec_rs1_read,
  input  logic [4:0] dec_rs2,
  input  logic       dec_rs2_read,
  input  logic       dec_mem_fence,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_rd_write,
  input  logic       ex_mem_read,
  input  logic       ex_branch_mispredict,
  input  logic       mem_trap,
  input  logic       fetch_wait,
  input  logic       data_wait,
  output logic       fetch_stall,
  output logic       decode_stall,
  output logic       execute_stall,
  output logic       mem_stall,
  output logic       fetch_flush,
  output logic       decode_flush,
  output logic       execute_flush,
  output logic       mem_flush,
  output logic       writeback_flush
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FENCE     = 2'd1,
    TRAP_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] FENCE_LOAD = 4'(FENCE_DRAIN_CYCLES - 1);
  localparam logic [3:0] TRAP_LOAD  = 4'(TRAP_HOLD_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       load_use, fence_entry, fence_hold;

  assign load_use = dec_valid & ex_valid & ex_mem_read & ex_rd_write & (ex_rd != 5'd0) &
                    ((dec_rs1_read & (dec_rs1 == ex_rd)) | (dec_rs2_read & (dec_rs2 == ex_rd)));
  assign fence_entry = (state == IDLE) & dec_valid & dec_mem_fence;
  assign fence_hold  = fence_entry | ((state == FENCE) & (cnt != 4'd0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output and next-state value gets a default first so no path
  // through the priority chain can infer a latch.
  always_comb begin
    fetch_stall     = 1'b0;
    decode_stall    = 1'b0;
    execute_stall   = 1'b0;
    mem_stall       = 1'b0;
    fetch_flush     = 1'b0;
    decode_flush    = 1'b0;
    execute_flush   = 1'b0;
    mem_flush       = 1'b0;
    writeback_flush = 1'b0;
    state_next      = state;
    cnt_next        = cnt;

    if (reset) begin
      fetch_flush     = 1'b1;
      decode_flush    = 1'b1;
      execute_flush   = 1'b1;
      mem_flush       = 1'b1;
      writeback_flush = 1'b1;
    end else if (data_wait) begin
      // Whole pipe frozen; a coincident trap is taken once the bus responds.
      fetch_stall     = 1'b1;
      decode_stall    = 1'b1;
      execute_stall   = 1'b1;
      mem_stall       = 1'b1;
      writeback_flush = 1'b1;
    end else if (mem_trap) begin
      fetch_flush   = 1'b1;
      decode_flush  = 1'b1;
      execute_flush = 1'b1;
      mem_flush     = 1'b1;
      state_next    = TRAP_HOLD;
      cnt_next      = TRAP_LOAD;
    end else if (state == TRAP_HOLD) begin
      fetch_flush  = 1'b1;
      decode_flush = 1'b1;
      if (cnt == 4'd0) state_next = IDLE;
      else             cnt_next   = cnt - 4'd1;
    end else if (ex_branch_mispredict) begin
      // Any fence in decode is squashed by the redirect, so drop the drain.
      fetch_flush  = 1'b1;
      decode_flush = 1'b1;
      state_next   = IDLE;
    end else if (fence_hold || load_use) begin
      fetch_stall   = 1'b1;
      decode_stall  = 1'b1;
      execute_flush = 1'b1;
      if (fence_entry) begin
        state_next = FENCE;
        cnt_next   = FENCE_LOAD;
      end else if ((state == FENCE) && (cnt != 4'd0)) begin
        cnt_next = cnt - 4'd1;
      end
    end else if (state == FENCE) begin
      // Release cycle: the fence moves on to execute at the next edge.
      state_next  = IDLE;
      fetch_flush = fetch_wait;
    end else if (fetch_wait) begin
      fetch_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Self-checking bench for rv32_pipeline_ctrl: per-cycle stimulus tables with
// expected control vectors queued on drive and popped when outputs are sampled.
module tb_rv32_pipeline_ctrl;

  typedef struct packed {
    logic       reset;
    logic       dec_valid;
    logic [4:0] rs1;
    logic       rs1_read;
    logic [4:0] rs2;
    logic       rs2_read;
    logic       fence;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_rd_write;
    logic       ex_mem_read;
    logic       mispredict;
    logic       mem_trap;
    logic       fetch_wait;
    logic       data_wait;
  } stim_t;

  // Vector order: {fetch/decode/execute/mem stall, fetch/decode/execute/mem/writeback flush}
  localparam logic [8:0] O_NONE  = 9'b0000_00000;
  localparam logic [8:0] O_RESET = 9'b0000_11111;
  localparam logic [8:0] O_LU    = 9'b1100_00100;
  localparam logic [8:0] O_DW    = 9'b1111_00001;
  localparam logic [8:0] O_TRAP  = 9'b0000_11110;
  localparam logic [8:0] O_FD    = 9'b0000_11000;
  localparam logic [8:0] O_FW    = 9'b0000_10000;

  logic       clk = 1'b0;
  logic       reset, dec_valid, dec_rs1_read, dec_rs2_read, dec_mem_fence;
  logic [4:0] dec_rs1, dec_rs2, ex_rd;
  logic       ex_valid, ex_rd_write, ex_mem_read, ex_branch_mispredict;
  logic       mem_trap, fetch_wait, data_wait;
  logic       fs, ds, es, ms, ff, df, ef, mf, wf;
  logic       fs1, ds1, es1, ms1, ff1, df1, ef1, mf1, wf1;
  logic [8:0] out_vec, out1_vec;

  logic [8:0] exp_q[$];
  logic [8:0] exp1_q[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  rv32_pipeline_ctrl #(.FENCE_DRAIN_CYCLES(3), .TRAP_HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs1_read(dec_rs1_read), .dec_rs2(dec_rs2), .dec_rs2_read(dec_rs2_read),
    .dec_mem_fence(dec_mem_fence), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_rd_write(ex_rd_write), .ex_mem_read(ex_mem_read),
    .ex_branch_mispredict(ex_branch_mispredict), .mem_trap(mem_trap),
    .fetch_wait(fetch_wait), .data_wait(data_wait),
    .fetch_stall(fs), .decode_stall(ds), .execute_stall(es), .mem_stall(ms),
    .fetch_flush(ff), .decode_flush(df), .execute_flush(ef), .mem_flush(mf),
    .writeback_flush(wf)
  );

  rv32_pipeline_ctrl #(.FENCE_DRAIN_CYCLES(1), .TRAP_HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs1_read(dec_rs1_read), .dec_rs2(dec_rs2), .dec_rs2_read(dec_rs2_read),
    .dec_mem_fence(dec_mem_fence), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_rd_write(ex_rd_write), .ex_mem_read(ex_mem_read),
    .ex_branch_mispredict(ex_branch_mispredict), .mem_trap(mem_trap),
    .fetch_wait(fetch_wait), .data_wait(data_wait),
    .fetch_stall(fs1), .decode_stall(ds1), .execute_stall(es1), .mem_stall(ms1),
    .fetch_flush(ff1), .decode_flush(df1), .execute_flush(ef1), .mem_flush(mf1),
    .writeback_flush(wf1)
  );

  assign out_vec  = {fs, ds, es, ms, ff, df, ef, mf, wf};
  assign out1_vec = {fs1, ds1, es1, ms1, ff1, df1, ef1, mf1, wf1};

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s = '0;
    s.reset = 1'b1;
    return s;
  endfunction

  function automatic stim_t fence_s();
    stim_t s;
    s = '0;
    s.dec_valid = 1'b1;
    s.fence     = 1'b1;
    return s;
  endfunction

  function automatic stim_t trap_s();
    stim_t s;
    s = '0;
    s.mem_trap = 1'b1;
    return s;
  endfunction

  function automatic stim_t mp_s();
    stim_t s;
    s = '0;
    s.mispredict = 1'b1;
    return s;
  endfunction

  // Load in execute writing rd, dependent-or-not instruction in decode.
  function automatic stim_t lw_s(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic rs1r, input logic [4:0] rs2, input logic rs2r);
    stim_t s;
    s = '0;
    s.ex_valid    = 1'b1;
    s.ex_mem_read = 1'b1;
    s.ex_rd_write = 1'b1;
    s.ex_rd       = rd;
    s.dec_valid   = 1'b1;
    s.rs1         = rs1;
    s.rs1_read    = rs1r;
    s.rs2         = rs2;
    s.rs2_read    = rs2r;
    return s;
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are sampled at +4.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #2;
    reset                = s.reset;
    dec_valid            = s.dec_valid;
    dec_rs1              = s.rs1;
    dec_rs1_read         = s.rs1_read;
    dec_rs2              = s.rs2;
    dec_rs2_read         = s.rs2_read;
    dec_mem_fence        = s.fence;
    ex_valid             = s.ex_valid;
    ex_rd                = s.ex_rd;
    ex_rd_write          = s.ex_rd_write;
    ex_mem_read          = s.ex_mem_read;
    ex_branch_mispredict = s.mispredict;
    mem_trap             = s.mem_trap;
    fetch_wait           = s.fetch_wait;
    data_wait            = s.data_wait;
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    st.push_back(rst_s()); ex.push_back(O_RESET);
    s = rst_s(); s.mem_trap = 1'b1; s.dec_valid = 1'b1; s.fence = 1'b1; s.data_wait = 1'b1;
    st.push_back(s);       ex.push_back(O_RESET);
    st.push_back(idle_s()); ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    st.push_back(lw_s(5'd5, 5'd0, 1'b0, 5'd5, 1'b1)); ex.push_back(O_LU);
    s = lw_s(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); s.ex_valid = 1'b0;
    st.push_back(s); ex.push_back(O_NONE);
    st.push_back(lw_s(5'd0, 5'd0, 1'b0, 5'd0, 1'b1)); ex.push_back(O_NONE);
    st.push_back(lw_s(5'd7, 5'd7, 1'b1, 5'd0, 1'b0)); ex.push_back(O_LU);
    st.push_back(lw_s(5'd7, 5'd7, 1'b0, 5'd7, 1'b0)); ex.push_back(O_NONE);
    s = lw_s(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); s.ex_mem_read = 1'b0;
    st.push_back(s); ex.push_back(O_NONE);
    s = lw_s(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); s.dec_valid = 1'b0;
    st.push_back(s); ex.push_back(O_NONE);
    s = lw_s(5'd9, 5'd0, 1'b0, 5'd9, 1'b1); s.fetch_wait = 1'b1;
    st.push_back(s); ex.push_back(O_LU);
    s = idle_s(); s.fetch_wait = 1'b1;
    st.push_back(s); ex.push_back(O_FW);
    s = lw_s(5'd3, 5'd3, 1'b1, 5'd3, 1'b1); s.ex_rd_write = 1'b0;
    st.push_back(s); ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_fence();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    for (int k = 0; k < 3; k++) begin
      st.push_back(fence_s()); ex.push_back(O_LU);
    end
    st.push_back(fence_s()); ex.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    st.push_back(fence_s()); ex.push_back(O_LU);
    st.push_back(fence_s()); ex.push_back(O_LU);
    s = fence_s(); s.data_wait = 1'b1;
    st.push_back(s); ex.push_back(O_DW);
    st.push_back(s); ex.push_back(O_DW);
    st.push_back(fence_s()); ex.push_back(O_LU);
    st.push_back(fence_s()); ex.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL fence[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_fence_short();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] ex1[$];
    logic [8:0] e, e1;
    st.push_back(rst_s());   ex.push_back(O_RESET); ex1.push_back(O_RESET);
    st.push_back(fence_s()); ex.push_back(O_LU);    ex1.push_back(O_LU);
    st.push_back(fence_s()); ex.push_back(O_LU);    ex1.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_LU);    ex1.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_NONE);  ex1.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      exp1_q.push_back(ex1[i]);
      #2;
      e  = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL fence_short_drain3[%0d]: got %b expected %b", i, out_vec, e);
      end
      checks++;
      if (out1_vec !== e1) begin
        errors++;
        $display("FAIL fence_short_drain1[%0d]: got %b expected %b", i, out1_vec, e1);
      end
    end
  endtask

  task automatic test_trap();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    st.push_back(trap_s()); ex.push_back(O_TRAP);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_NONE);
    st.push_back(trap_s()); ex.push_back(O_TRAP);
    st.push_back(trap_s()); ex.push_back(O_TRAP);
    st.push_back(idle_s()); ex.push_back(O_FD);
    s = lw_s(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); s.mispredict = 1'b1;
    st.push_back(s);        ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_NONE);
    st.push_back(trap_s()); ex.push_back(O_TRAP);
    s = idle_s(); s.data_wait = 1'b1;
    st.push_back(s);        ex.push_back(O_DW);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL trap[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_trap_vs_data_wait();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    s = trap_s(); s.data_wait = 1'b1;
    st.push_back(s);        ex.push_back(O_DW);
    st.push_back(s);        ex.push_back(O_DW);
    st.push_back(trap_s()); ex.push_back(O_TRAP);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_FD);
    st.push_back(idle_s()); ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL trap_vs_data_wait[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_mispredict();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    st.push_back(mp_s()); ex.push_back(O_FD);
    s = lw_s(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); s.mispredict = 1'b1;
    st.push_back(s);         ex.push_back(O_FD);
    st.push_back(fence_s()); ex.push_back(O_LU);
    st.push_back(fence_s()); ex.push_back(O_LU);
    s = fence_s(); s.mispredict = 1'b1;
    st.push_back(s);         ex.push_back(O_FD);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    s = mp_s(); s.fetch_wait = 1'b1;
    st.push_back(s);         ex.push_back(O_FD);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL mispredict[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    stim_t s;
    for (int k = 0; k < 3; k++) begin
      st.push_back(fence_s()); ex.push_back(O_LU);
    end
    s = fence_s(); s.fetch_wait = 1'b1;
    st.push_back(s); ex.push_back(O_FW);
    for (int k = 0; k < 3; k++) begin
      st.push_back(fence_s()); ex.push_back(O_LU);
    end
    s = lw_s(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); s.fence = 1'b1;
    st.push_back(s);         ex.push_back(O_LU);
    st.push_back(fence_s()); ex.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    stim_t st[$];
    logic [8:0] ex[$];
    logic [8:0] e;
    st.push_back(trap_s());  ex.push_back(O_TRAP);
    st.push_back(rst_s());   ex.push_back(O_RESET);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    st.push_back(fence_s()); ex.push_back(O_LU);
    st.push_back(rst_s());   ex.push_back(O_RESET);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    st.push_back(idle_s());  ex.push_back(O_NONE);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL reset_mid_hold[%0d]: got %b expected %b", i, out_vec, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs1_read = 1'b0;
    dec_rs2 = 5'd0; dec_rs2_read = 1'b0; dec_mem_fence = 1'b0; ex_valid = 1'b0;
    ex_rd = 5'd0; ex_rd_write = 1'b0; ex_mem_read = 1'b0; ex_branch_mispredict = 1'b0;
    mem_trap = 1'b0; fetch_wait = 1'b0; data_wait = 1'b0;
    test_reset();
    test_load_use();
    test_fence();
    test_fence_short();
    test_trap();
    test_trap_vs_data_wait();
    test_mispredict();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
